hex_scroll_ctrl: RTL and testbench

- Sequences a short message of 3-bit character codes across a row of active-low 7-segment displays. The text scrolls right-to-left at a fixed tick rate.
- Holds a small message buffer, filled through a valid/ready load port.
- Contains a rate divider and a run/pause/clear state machine.
- Drives one combinational char-to-segment decoder per digit. Sits between switch/key front-end logic and the HEX pins.

---
 rtl/hex_scroll_pkg.sv | 23 ++
 rtl/char_7seg.sv | 21 ++
 rtl/hex_scroll_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_hex_scroll_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_scroll_pkg.sv
// Shared types and constants for the scrolling 7-segment message controller.
package hex_scroll_pkg;

    typedef logic [2:0] char_code_t;

    localparam char_code_t CODE_H     = 3'b000;
    localparam char_code_t CODE_E     = 3'b001;
    localparam char_code_t CODE_L     = 3'b010;
    localparam char_code_t CODE_O     = 3'b011;
    localparam char_code_t CODE_P     = 3'b100;
    localparam char_code_t CODE_BLANK = 3'b111;

    typedef enum logic [1:0] {IDLE, FILL, RUN, PAUSE} state_t;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/char_7seg.sv
// Combinational character-code to active-low 7-segment decoder.
module char_7seg
    import hex_scroll_pkg::*;
(
    input  char_code_t code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            CODE_H:  seg = SEG_H;
            CODE_E:  seg = SEG_E;
            CODE_L:  seg = SEG_L;
            CODE_O:  seg = SEG_O;
            CODE_P:  seg = SEG_P;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Scrolls a loadable message right-to-left across NUM_DIGITS 7-seg displays.
// Define HEX_SCROLL_BLINK_EN to blink the frozen display while paused.
module hex_scroll_ctrl
    import hex_scroll_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 5,
    parameter int unsigned MSG_LEN    = 8,
    parameter int unsigned TICK_DIV   = 25000000
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    load_valid,
    input  logic [2:0]              load_code,
    output logic                    load_ready,
    input  logic                    start,
    input  logic                    run,
    input  logic                    clear,
    output logic [7*NUM_DIGITS-1:0] HEX,
    output logic                    busy,
    output logic                    wrap_pulse
);

    localparam int unsigned CntW    = $clog2(MSG_LEN + 1);
    localparam int unsigned IdxW    = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int unsigned StreamN = MSG_LEN + NUM_DIGITS;
    localparam int unsigned OffW    = $clog2(StreamN);
    localparam int unsigned DivW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t               state_q, state_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [OffW-1:0]      off_q, off_d;
    logic [DivW-1:0]      div_q, div_d;
    logic                 wrap_q, wrap_d;
    logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
    char_code_t           msg_q [MSG_LEN];
    char_code_t           stream [StreamN];
    char_code_t           digit_code [NUM_DIGITS];
    logic [OffW:0]        plen;
    logic                 wr_en, tick, last_off, show;

`ifdef HEX_SCROLL_BLINK_EN
    logic blink_q, blink_d;
`endif

    assign load_ready = ((state_q == IDLE) || (state_q == FILL)) && (count_q < CntW'(MSG_LEN));
    assign wr_en      = load_valid && load_ready && !clear;
    assign plen       = (OffW + 1)'(count_q) + (OffW + 1)'(NUM_DIGITS);
    assign tick       = (div_q == DivW'(TICK_DIV - 1));
    assign last_off   = (off_q == OffW'(plen - 1'b1));
    assign busy       = (state_q == RUN) || (state_q == PAUSE);
    assign wrap_pulse = wrap_q;
    assign HEX        = hex_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        off_d   = off_q;
        div_d   = div_q;
        wrap_d  = 1'b0;
`ifdef HEX_SCROLL_BLINK_EN
        blink_d = blink_q;
`endif
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            off_d   = '0;
            div_d   = '0;
`ifdef HEX_SCROLL_BLINK_EN
            blink_d = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE, FILL: begin
                    if (wr_en) begin
                        count_d = count_q + 1'b1;
                        state_d = FILL;
                    end
                    // A write accepted alongside start counts toward the message length.
                    if (start && (count_d != '0)) begin
                        state_d = run ? RUN : PAUSE;
                        off_d   = '0;
                        div_d   = '0;
                    end
                end
                RUN: begin
                    if (!run) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        div_d = '0;
                        if (last_off) begin
                            off_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            off_d = off_q + 1'b1;
                        end
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                PAUSE: begin
                    if (run) begin
                        state_d = RUN;
`ifdef HEX_SCROLL_BLINK_EN
                        blink_d = 1'b0;
                    end else if (tick) begin
                        div_d   = '0;
                        blink_d = !blink_q;
                    end else begin
                        div_d = div_q + 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef HEX_SCROLL_BLINK_EN
    assign show = busy && !blink_q;
`else
    assign show = busy;
`endif

    // Virtual stream: message followed by NUM_DIGITS blanks, read circularly.
    always_comb begin
        logic [OffW:0] sum;
        for (int unsigned i = 0; i < StreamN; i++) begin
            stream[i] = CODE_BLANK;
        end
        for (int unsigned i = 0; i < MSG_LEN; i++) begin
            stream[i] = (CntW'(i) < count_q) ? msg_q[i] : CODE_BLANK;
        end
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            sum = {1'b0, off_q} + (OffW + 1)'(NUM_DIGITS - 1 - k);
            if (sum >= plen) begin
                sum = sum - plen;
            end
            digit_code[k] = show ? stream[sum[OffW-1:0]] : CODE_BLANK;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        char_7seg u_char_7seg (
            .code (digit_code[k]),
            .seg  (hex_d[7*k +: 7])
        );
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            off_q   <= '0;
            div_q   <= '0;
            wrap_q  <= 1'b0;
            hex_q   <= '1;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            off_q   <= off_d;
            div_q   <= div_d;
            wrap_q  <= wrap_d;
            hex_q   <= hex_d;
        end
    end

`ifdef HEX_SCROLL_BLINK_EN
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end
`endif

    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            msg_q[count_q[IdxW-1:0]] <= load_code;
        end
    end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Self-checking bench for hex_scroll_ctrl (default build, TICK_DIV=4).
module tb_hex_scroll_ctrl;

    localparam int ND = 5;
    localparam int ML = 8;
    localparam int TD = 4;
    localparam logic [34:0] BLANK_ALL = {35{1'b1}};

    localparam int MIdle  = 0;
    localparam int MFill  = 1;
    localparam int MRun   = 2;
    localparam int MPause = 3;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic [2:0]  load_code = 3'd0;
    logic        load_ready;
    logic        start = 1'b0;
    logic        run = 1'b0;
    logic        clear = 1'b0;
    logic [34:0] HEX;
    logic        busy;
    logic        wrap_pulse;

    int ncmp = 0;
    int nerr = 0;

    // Reference model: message queue, mode, and cycles spent advancing since start.
    int          mode = MIdle;
    logic [2:0]  msg[$];
    int unsigned adv = 0;
    logic [34:0] exp_hex = BLANK_ALL;
    logic        exp_wrap = 1'b0;

    hex_scroll_ctrl #(
        .NUM_DIGITS (ND),
        .MSG_LEN    (ML),
        .TICK_DIV   (TD)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .load_valid (load_valid),
        .load_code  (load_code),
        .load_ready (load_ready),
        .start      (start),
        .run        (run),
        .clear      (clear),
        .HEX        (HEX),
        .busy       (busy),
        .wrap_pulse (wrap_pulse)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [6:0] glyph(input logic [2:0] c);
        case (c)
            3'd0:    return 7'b0001001;
            3'd1:    return 7'b0000110;
            3'd2:    return 7'b1000111;
            3'd3:    return 7'b1000000;
            3'd4:    return 7'b0001100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int plen();
        return msg.size() + ND;
    endfunction

    function automatic logic [34:0] disp();
        logic [34:0] h;
        int off, idx;
        h = BLANK_ALL;
        if (mode == MRun || mode == MPause) begin
            off = int'(adv / TD) % plen();
            for (int k = 0; k < ND; k++) begin
                idx = (off + ND - 1 - k) % plen();
                h[7*k +: 7] = glyph((idx < msg.size()) ? msg[idx] : 3'b111);
            end
        end
        return h;
    endfunction

    function automatic bit ready_m();
        return (mode == MIdle || mode == MFill) && (msg.size() < ML);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [34:0] nhex;
        logic        nwrap;
        bit          wr;
        nhex  = disp();
        nwrap = 1'b0;
        wr    = load_valid && ready_m();
        if (clear) begin
            mode = MIdle;
            msg.delete();
            adv = 0;
        end else if (mode == MRun) begin
            if (!run) mode = MPause;
            else begin
                adv++;
                if (adv % (TD * plen()) == 0) nwrap = 1'b1;
            end
        end else if (mode == MPause) begin
            if (run) mode = MRun;
        end else begin
            if (wr) begin
                msg.push_back(load_code);
                mode = MFill;
            end
            if (start && msg.size() > 0) begin
                mode = run ? MRun : MPause;
                adv  = 0;
            end
        end
        @(posedge CLOCK_50);
        #1;
        exp_hex  = nhex;
        exp_wrap = nwrap;
        chk("hex", 64'(HEX), 64'(exp_hex));
        chk("wrap_pulse", 64'(wrap_pulse), 64'(exp_wrap));
        chk("busy", 64'(busy), 64'(mode == MRun || mode == MPause));
        chk("load_ready", 64'(load_ready), 64'(ready_m()));
    endtask

    task automatic idle_inputs();
        load_valid = 1'b0;
        start      = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic write(input logic [2:0] c);
        load_valid = 1'b1;
        load_code  = c;
        step();
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        #1;
        mode = MIdle;
        msg.delete();
        adv = 0;
        exp_hex = BLANK_ALL;
        chk("reset_hex", 64'(HEX), 64'(BLANK_ALL));
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ready", 64'(load_ready), 64'd1);
        chk("reset_wrap", 64'(wrap_pulse), 64'd0);
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge CLOCK_50);
        #1 reset = 1'b0;
        chk("por_hex", 64'(HEX), 64'(BLANK_ALL));
        chk("por_busy", 64'(busy), 64'd0);
        chk("por_ready", 64'(load_ready), 64'd1);
        steps(2);

        // Fill to full: nine writes, the ninth refused
        load_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            load_code = 3'($urandom_range(0, 7));
            step();
        end
        idle_inputs();
        run = 1'b1;
        pulse_start();
        steps(4 * (ML + ND) + 6);
        async_reset();

        // Two characters, scroll through one full wrap
        write(3'd0);
        write(3'd1);
        run = 1'b1;
        pulse_start();
        steps(32);

        // Pause mid-period, then resume
        steps(2);
        run = 1'b0;
        steps(20);
        run = 1'b1;
        steps(12);

        // Clear with load_valid in the same cycle during FILL; start afterwards ignored
        clear = 1'b1;
        step();
        clear = 1'b0;
        write(3'd2);
        clear      = 1'b1;
        load_valid = 1'b1;
        load_code  = 3'd3;
        step();
        idle_inputs();
        pulse_start();
        steps(3);

        // Start together with an accepted write
        write(3'd4);
        write(3'd2);
        load_valid = 1'b1;
        load_code  = 3'd3;
        start      = 1'b1;
        step();
        idle_inputs();
        steps(4 * 8 + 4);

        // Start with run low enters pause directly
        clear = 1'b1;
        step();
        clear = 1'b0;
        write(3'd1);
        run = 1'b0;
        pulse_start();
        steps(6);
        run = 1'b1;
        steps(10);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_code  = 3'($urandom_range(0, 7));
            start      = ($urandom_range(0, 15) == 0);
            run        = ($urandom_range(0, 7) != 0);
            clear      = ($urandom_range(0, 79) == 0);
            step();
        end
        idle_inputs();
        steps(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
